matmul_2dmesh_nxn: RTL and testbench
====================================

Name: matmul_2dmesh_nxn

Overview:
- Parametrised N×N systolic 2D-mesh matrix multiplier; next generation of the fixed 2×2 mesh multiplier.
- Computes C = A·B for unsigned DW-bit operands, or C += A·B in accumulate mode.
- Operands stream in through a valid/ready handshake, one beat per column of A and row of B; internal skew registers feed the mesh.
- Controller FSM, skew chains and PE array are all inside this block.

Parameters:
- N, 4, matrix dimension (2..8).
- DW, 4, operand width in bits.
- AW, 2*DW+$clog2(N), accumulator/result width; must be at least 2*DW+$clog2(N).

Ports:
- CLK  in  1  master clock.
- RST  in  1  master reset; synchronous, active-low.
- STM  in  1  start multiplication; sampled only in IDLE.
- ACC  in  1  accumulate mode; sampled together with STM.
- IN_VLD  in  1  operand beat valid.
- IN_RDY  out  1  operand beat ready.
- A_COL  in  N*DW  column k of A; element A[i][k] at bits [i*DW +: DW].
- B_ROW  in  N*DW  row k of B; element B[k][j] at bits [j*DW +: DW].
- MTX  out  N*N*AW  result; C[i][j] at bits [(i*N+j)*AW +: AW].
- BUSY  out  1  high outside IDLE.
- EOM  out  1  end of multiplication; 1-cycle pulse.

Behaviour:
- Reset (RST=0 at a CLK edge): state=IDLE, all accumulators=0, all skew/pass registers=0, beat and drain counters=0, IN_RDY=0, BUSY=0, EOM=0. Reset mid-operation aborts the operation, clears MTX and produces no EOM.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - On STM=1: go to LOAD.
  - If ACC=0, all accumulators clear on that same edge.
  - If ACC=1, accumulators are kept.
- LOAD:
  - IN_RDY=1.
  - A beat is accepted when IN_VLD=1 and IN_RDY=1.
  - Beat counter k runs 0..N-1; after beat N-1 is accepted, go to DRAIN.
- DRAIN: runs exactly 2N-2 cycles, injecting zeros at the edges; then go to DONE.
- DONE: EOM=1 for one cycle, then IDLE.
- Mesh enable:
  - en = (LOAD & IN_VLD) | DRAIN.
  - All skew, pass and accumulator registers update only when en=1.
  - An IN_VLD gap therefore freezes the whole array; results are unaffected by stalls.
- Skew:
  - Row i of A is delayed by i enabled cycles before entering PE(i,0).
  - Column j of B is delayed by j enabled cycles before entering PE(0,j).
- PE(i,j), on each enabled edge:
  - acc <= acc + a_in*b_in.
  - a passes east; b passes south, each through one register.
  - A[i][k] and B[k][j] meet at PE(i,j) on enabled edge k+i+j.
  - The last MAC occurs on enabled edge 3N-3.
- Arithmetic: unsigned; product is 2*DW bits, zero-extended to AW. ACC-mode overflow wraps modulo 2^AW.
- Latency: with IN_VLD held high and STM in cycle 0:
  - beats are accepted in cycles 1..N;
  - DRAIN occupies cycles N+1..3N-2;
  - EOM is high in cycle 3N-1 (N=2 → cycle 5; N=4 → cycle 11).
  - Each IN_VLD=0 cycle in LOAD adds one cycle.
- MTX is driven directly from the accumulators. It is final from the EOM cycle and held until the next accepted STM. Intermediate values are visible while BUSY=1.
- STM while BUSY: ignored.
- STM in the same cycle as EOM: ignored (state is DONE).
- IN_VLD outside LOAD: ignored; IN_RDY=0.

Decomposition:
- Package mesh_pkg:
  - state enum {IDLE, LOAD, DRAIN, DONE};
  - default N, DW;
  - AW derivation function;
  - DRAIN_CYC = 2N-2 constant.
- Sub-module pe_mac: one processing element with a/b pass registers, enable, clear, and an AW-bit accumulator.
- Top level contains: the FSM, beat/drain counters, the skew shift-register chains, and a generate loop instantiating N×N pe_mac.

Test Plan:
- N=2, DW=4, ACC=0. Stimulus: A=[[1,2],[3,4]], B=identity, IN_VLD always 1. Required: EOM in cycle 5; MTX=[[1,2],[3,4]]; BUSY high cycles 1..5.
- N=2, DW=4. Stimulus: all operands 15. Required: every C entry = 450 (fits AW=9); no wrap.
- N=4, DW=4. Stimulus: A[i][k]=i+k, B[k][j]=k*j, with IN_VLD deasserted for 2 cycles after beat 1. Required: MTX matches the reference product; EOM in cycle 13; IN_RDY low only outside LOAD.
- N=2, accumulate. Stimulus: run with ACC=0 (A=B=identity), then again with ACC=1 (same operands). Required: after run 2, MTX=[[2,0],[0,2]]. A third run with ACC=0 gives identity again.
- N=2, reset mid-operation. Stimulus: RST=0 during DRAIN. Required: next cycle state=IDLE, MTX=0, BUSY=0, no EOM pulse.
- N=2, STM ignored. Stimulus: STM pulsed in LOAD and in the DONE cycle. Required: no restart; result and EOM timing unchanged.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared definitions for the N x N systolic matrix multiplier.
//   state_e      : controller states (IDLE, LOAD, DRAIN, DONE)
//   DEF_N/DEF_DW : default matrix dimension and operand width
//   calc_aw()    : minimum accumulator width that cannot overflow in one run
//   drain_cycles(): cycles needed after the last beat to flush the mesh
package mesh_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_N  = 4;
    localparam int DEF_DW = 4;

    // A sum of n products of two dw-bit values needs 2*dw + clog2(n) bits.
    function automatic int calc_aw(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    // The last operand pair meets at PE(n-1,n-1) 2n-2 enabled edges after
    // the final beat is accepted.
    function automatic int drain_cycles(input int n);
        return 2 * n - 2;
    endfunction

    localparam int DRAIN_CYC = drain_cycles(DEF_N);

endpackage

// File: rtl/pe_mac.sv
// One processing element of the systolic mesh.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   en_i          : mesh-wide advance enable; everything freezes when low
//   clr_i         : clears the accumulator (start of a non-accumulating run)
//   a_i / a_o     : A operand in from the west, registered copy out east
//   b_i / b_o     : B operand in from the north, registered copy out south
//   acc_o         : running sum of a_i*b_i, wraps modulo 2^AW
module pe_mac
    import mesh_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = calc_aw(DEF_N, DEF_DW)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] b_o,
    output logic [AW-1:0] acc_o
);

    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_d;
    logic [2*DW-1:0] prod;

    assign prod = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + AW'(prod);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (en_i) begin
                a_q <= a_i;
                b_q <= b_i;
            end
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/matmul_2dmesh_nxn.sv
// N x N systolic 2D-mesh matrix multiplier: C = A*B, or C += A*B (ACC=1).
//   CLK, RST      : clock, synchronous active-low reset
//   STM, ACC      : start / accumulate mode, sampled only in IDLE
//   IN_VLD/IN_RDY : operand beat handshake
//   A_COL, B_ROW  : column k of A and row k of B for beat k
//   MTX           : all N*N accumulators, C[i][j] at [(i*N+j)*AW +: AW]
//   BUSY, EOM     : not idle / one-cycle end-of-multiplication pulse
//   DBG_STATE     : controller state, for observation only
//
// Handshake: a beat transfers on a rising edge where IN_VLD and IN_RDY are
// both 1. IN_RDY is high for the whole LOAD state and never depends on
// IN_VLD; IN_VLD outside LOAD is ignored.
module matmul_2dmesh_nxn
    import mesh_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int AW = calc_aw(N, DW)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STM,
    input  logic              ACC,
    input  logic              IN_VLD,
    output logic              IN_RDY,
    input  logic [N*DW-1:0]   A_COL,
    input  logic [N*DW-1:0]   B_ROW,
    output logic [N*N*AW-1:0] MTX,
    output logic              BUSY,
    output logic              EOM,
    output state_e            DBG_STATE
);

    localparam int CW      = $clog2(2 * N);
    localparam int DRAIN_N = drain_cycles(N);

    state_e        state_q, state_d;
    logic [CW-1:0] beat_q, beat_d;
    logic [CW-1:0] drain_q, drain_d;
    logic          en;
    logic          clr;

    // ---------------- controller ----------------
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (STM) begin
                    state_d = LOAD;
                    beat_d  = '0;
                    drain_d = '0;
                    clr     = !ACC;
                end
            end
            LOAD: begin
                if (IN_VLD) begin
                    if (beat_q == CW'(N - 1)) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == CW'(DRAIN_N - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            beat_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
        end
    end

    // A stalled beat freezes the entire array, so results do not depend on
    // IN_VLD gaps.
    assign en        = ((state_q == LOAD) && IN_VLD) || (state_q == DRAIN);
    assign IN_RDY    = (state_q == LOAD);
    assign BUSY      = (state_q != IDLE);
    assign EOM       = (state_q == DONE);
    assign DBG_STATE = state_q;

    // ---------------- edge sources ----------------
    // Zeros are injected at the mesh edges during DRAIN.
    logic [DW-1:0] a_src [N];
    logic [DW-1:0] b_src [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_src[i] = '0;
            b_src[i] = '0;
            if (state_q == LOAD) begin
                a_src[i] = A_COL[i*DW +: DW];
                b_src[i] = B_ROW[i*DW +: DW];
            end
        end
    end

    // a_h[i][j] feeds PE(i,j) from the west; b_v[i][j] feeds it from the north.
    logic [DW-1:0] a_h [N][N+1];
    logic [DW-1:0] b_v [N+1][N];

    // ---------------- skew chains ----------------
    // Row i of A and column i of B are delayed by i enabled cycles so that
    // A[i][k] and B[k][j] reach PE(i,j) on the same enabled edge k+i+j.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign a_h[0][0] = a_src[0];
            assign b_v[0][0] = b_src[0];
        end else begin : g_chain
            logic [DW-1:0] a_sr_q [gi];
            logic [DW-1:0] b_sr_q [gi];

            always_ff @(posedge CLK) begin
                if (!RST) begin
                    for (int s = 0; s < gi; s++) begin
                        a_sr_q[s] <= '0;
                        b_sr_q[s] <= '0;
                    end
                end else if (en) begin
                    a_sr_q[0] <= a_src[gi];
                    b_sr_q[0] <= b_src[gi];
                    for (int s = 1; s < gi; s++) begin
                        a_sr_q[s] <= a_sr_q[s-1];
                        b_sr_q[s] <= b_sr_q[s-1];
                    end
                end
            end

            assign a_h[gi][0] = a_sr_q[gi-1];
            assign b_v[0][gi] = b_sr_q[gi-1];
        end
    end

    // ---------------- PE array ----------------
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            pe_mac #(
                .DW(DW),
                .AW(AW)
            ) u_pe (
                .clk_i (CLK),
                .rst_ni(RST),
                .en_i  (en),
                .clr_i (clr),
                .a_i   (a_h[gi][gj]),
                .b_i   (b_v[gi][gj]),
                .a_o   (a_h[gi][gj+1]),
                .b_o   (b_v[gi+1][gj]),
                .acc_o (MTX[(gi*N+gj)*AW +: AW])
            );
        end
    end

    // Operands leaving the east and south edges have no consumer.
    logic unused_edge;
    always_comb begin
        unused_edge = 1'b0;
        for (int i = 0; i < N; i++) begin
            unused_edge = unused_edge ^ (^a_h[i][N]) ^ (^b_v[N][i]);
        end
    end

endmodule

// File: tb/tb_matmul_2dmesh_nxn.sv
module tb_matmul_2dmesh_nxn;
  import mesh_pkg::*;

  localparam int DW  = 4;
  localparam int AW2 = 9;   // 2*4 + clog2(2)
  localparam int AW4 = 10;  // 2*4 + clog2(4)
  localparam int MW  = 16 * AW4;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic RST;
  int   cyc = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic            stm2, acc2, vld2, rdy2, busy2, eom2;
  logic [2*DW-1:0] a2, b2;
  logic [4*AW2-1:0] mtx2;
  state_e          st2;

  logic            stm4, acc4, vld4, rdy4, busy4, eom4;
  logic [4*DW-1:0] a4, b4;
  logic [16*AW4-1:0] mtx4;
  state_e          st4;

  matmul_2dmesh_nxn #(.N(2), .DW(DW)) dut2 (
    .CLK(CLK), .RST(RST), .STM(stm2), .ACC(acc2), .IN_VLD(vld2), .IN_RDY(rdy2),
    .A_COL(a2), .B_ROW(b2), .MTX(mtx2), .BUSY(busy2), .EOM(eom2), .DBG_STATE(st2)
  );

  matmul_2dmesh_nxn #(.N(4), .DW(DW)) dut4 (
    .CLK(CLK), .RST(RST), .STM(stm4), .ACC(acc4), .IN_VLD(vld4), .IN_RDY(rdy4),
    .A_COL(a4), .B_ROW(b4), .MTX(mtx4), .BUSY(busy4), .EOM(eom4), .DBG_STATE(st4)
  );

  // ---------------- reference model / scoreboard ----------------
  int        ma [4][4];
  int        mb [4][4];
  longint    mc [2][4][4];
  logic [MW-1:0] exp2_q[$];
  logic [MW-1:0] exp4_q[$];
  int        cyc2_q[$];
  int        cyc4_q[$];
  int        total = 0;
  int        bad   = 0;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int dim(input int sel);
    return (sel != 0) ? 4 : 2;
  endfunction

  function automatic logic get_rdy(input int sel);
    return (sel != 0) ? rdy4 : rdy2;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy4 : busy2;
  endfunction

  function automatic logic [MW-1:0] get_mtx(input int sel);
    return (sel != 0) ? MW'(mtx4) : MW'(mtx2);
  endfunction

  function automatic state_e get_state(input int sel);
    return (sel != 0) ? st4 : st2;
  endfunction

  // C (+)= A*B by the textbook triple sum, wrapped to the result width.
  task automatic model_run(input int sel, input bit acc, output logic [MW-1:0] e);
    int     n;
    int     aw;
    longint s;
    n  = dim(sel);
    aw = (sel != 0) ? AW4 : AW2;
    e  = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
        if (!acc) mc[sel][i][j] = 0;
        mc[sel][i][j] = (mc[sel][i][j] + s) % (longint'(1) << aw);
        if (sel != 0) e[(i*4+j)*AW4 +: AW4] = AW4'(mc[sel][i][j]);
        else          e[(i*2+j)*AW2 +: AW2] = AW2'(mc[sel][i][j]);
      end
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) mc[s][i][j] = 0;
  endtask

  // ---------------- monitor ----------------
  task automatic monitor_step();
    logic [MW-1:0] e;
    int ec;
    if (eom2 === 1'b1) begin
      if (exp2_q.size() == 0) begin
        check("eom2_unexpected", 1, 0);
      end else begin
        e  = exp2_q.pop_front();
        ec = cyc2_q.pop_front();
        check("mtx2", MW'(mtx2), e);
        check("eom2_cycle", MW'(cyc), MW'(ec));
      end
    end
    if (eom4 === 1'b1) begin
      if (exp4_q.size() == 0) begin
        check("eom4_unexpected", 1, 0);
      end else begin
        e  = exp4_q.pop_front();
        ec = cyc4_q.pop_front();
        check("mtx4", MW'(mtx4), e);
        check("eom4_cycle", MW'(cyc), MW'(ec));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input int sel, input bit stm, input bit acc, input bit vld, input int k);
    logic [15:0] av;
    logic [15:0] bv;
    int n;
    n  = dim(sel);
    av = '0;
    bv = '0;
    if (vld) begin
      for (int i = 0; i < n; i++) begin
        av[i*DW +: DW] = 4'(ma[i][k]);
        bv[i*DW +: DW] = 4'(mb[k][i]);
      end
    end
    if (sel != 0) begin
      stm4 = stm; acc4 = acc; vld4 = vld; a4 = av; b4 = bv;
    end else begin
      stm2 = stm; acc2 = acc; vld2 = vld; a2 = av[7:0]; b2 = bv[7:0];
    end
  endtask

  // stall_mode: 0 none, 1 gap_len idle cycles after beat gap_after, 2 random.
  task automatic run(input int sel, input bit acc, input int stall_mode, input int gap_after,
                     input int gap_len, input bit stm_noise, input bit abort);
    int n, stalls, k, t0, exp_eom;
    bit pat[$];
    bit load_bad, drain_bad;
    logic [MW-1:0] e;
    n = dim(sel);
    stalls = 0;
    for (int bt = 0; bt < n; bt++) begin
      if (stall_mode == 2)
        while (stalls < 6 && $urandom_range(0, 3) == 0) begin pat.push_back(1'b0); stalls++; end
      pat.push_back(1'b1);
      if (stall_mode == 1 && bt == gap_after)
        for (int g = 0; g < gap_len; g++) begin pat.push_back(1'b0); stalls++; end
    end

    @(posedge CLK); #1;
    t0 = cyc;
    exp_eom = t0 + 3 * n - 1 + stalls;
    if (!abort) begin
      model_run(sel, acc, e);
      if (sel != 0) begin exp4_q.push_back(e); cyc4_q.push_back(exp_eom); end
      else          begin exp2_q.push_back(e); cyc2_q.push_back(exp_eom); end
    end
    set_in(sel, 1'b1, acc, 1'b0, 0);
    check("rdy_idle", MW'(get_rdy(sel)), 0);
    check("busy_idle", MW'(get_busy(sel)), 0);
    @(posedge CLK); #1;

    load_bad = 1'b0;
    k = 0;
    foreach (pat[p]) begin
      set_in(sel, stm_noise && p == 1, acc, pat[p], k);
      if (get_rdy(sel) !== 1'b1 || get_busy(sel) !== 1'b1) load_bad = 1'b1;
      if (pat[p]) k++;
      @(posedge CLK); #1;
    end
    set_in(sel, 1'b0, acc, 1'b0, 0);
    check("load_rdy_busy", MW'(load_bad), 0);

    if (abort) begin
      RST = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b1;
      model_reset();
      check("abort_state", MW'(get_state(sel)), MW'(IDLE));
      check("abort_mtx", get_mtx(sel), 0);
      check("abort_busy", MW'(get_busy(sel)), 0);
      repeat (6) @(posedge CLK);
      #1;
      return;
    end

    drain_bad = 1'b0;
    while (cyc <= exp_eom) begin
      if (get_busy(sel) !== 1'b1 || get_rdy(sel) !== 1'b0) drain_bad = 1'b1;
      set_in(sel, stm_noise && cyc == exp_eom, acc, 1'b0, 0);
      @(posedge CLK); #1;
    end
    set_in(sel, 1'b0, acc, 1'b0, 0);
    check("drain_busy_rdy", MW'(drain_bad), 0);
    check("busy_after", MW'(get_busy(sel)), 0);
    check("eom_seen", MW'((sel != 0) ? exp4_q.size() : exp2_q.size()), 0);
  endtask

  task automatic set_ident(input int n);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = (i == j && i < n) ? 1 : 0;
        mb[i][j] = ma[i][j];
      end
  endtask

  task automatic set_random();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = $urandom_range(0, 15);
        mb[i][j] = $urandom_range(0, 15);
      end
  endtask

  // ---------------- main ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0;
    set_in(0, 1'b0, 1'b0, 1'b0, 0);
    set_in(1, 1'b0, 1'b0, 1'b0, 0);
    model_reset();
    fork
      forever begin
        @(negedge CLK);
        monitor_step();
      end
    join_none

    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    check("rst_state2", MW'(st2), MW'(IDLE));
    check("rst_state4", MW'(st4), MW'(IDLE));
    check("rst_mtx2", MW'(mtx2), 0);
    check("rst_mtx4", MW'(mtx4), 0);
    check("rst_flags2", MW'({rdy2, busy2, eom2}), 0);
    check("rst_flags4", MW'({rdy4, busy4, eom4}), 0);

    // A = [[1,2],[3,4]], B = identity
    set_ident(2);
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    run(0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // all-15 operands: 2 * 225 = 450 everywhere
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin ma[i][j] = 15; mb[i][j] = 15; end
    run(0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // N=4, A[i][k]=i+k, B[k][j]=k*j, 2-cycle gap after beat 1
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin ma[i][j] = i + j; mb[i][j] = i * j; end
    run(1, 1'b0, 1, 1, 2, 1'b0, 1'b0);

    // accumulate sequence: I, then 2I, then I again
    set_ident(2);
    run(0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    run(0, 1'b1, 0, 0, 0, 1'b0, 1'b0);
    run(0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // reset during DRAIN
    set_random();
    run(0, 1'b0, 0, 0, 0, 1'b0, 1'b1);

    // STM pulses in LOAD and in the DONE cycle are ignored
    set_random();
    run(0, 1'b0, 0, 0, 0, 1'b1, 1'b0);

    // randomized operands, modes and stalls on both sizes
    for (int r = 0; r < 16; r++) begin
      set_random();
      run(r % 2, 1'($urandom_range(0, 1)), 2, 0, 0, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (4) @(posedge CLK);
    #1;
    check("queue2_empty", MW'(exp2_q.size()), 0);
    check("queue4_empty", MW'(exp4_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
